decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_if.sv | 48 ++++
 rtl/decoder.sv | 176 +++++++++++++++++
 tb/tb_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_if.sv
// Decode-stage bundle: instruction inputs, register-file ports and decode results.
`default_nettype none

interface decoder_if;
  logic [31:0] Instr;
  logic [31:0] Instr_PC_Plus4;
  logic [31:0] RegisterValue;
  logic [4:0]  RegA;
  logic [4:0]  RegB;
  logic [4:0]  RegC;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [31:0] DataC;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Write;
  logic        Link;
  logic        RegDest;
  logic        Jump;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic        JumpRegister;
  logic        SignOrZero;
  logic        Syscall;
  logic [5:0]  ALUControl;
  logic [31:0] NextInstructionAddress;

  modport master (
    output Instr, Instr_PC_Plus4, RegisterValue, RegA, RegB, RegC,
           WriteReg, WriteData, Write,
    input  DataA, DataB, DataC, Link, RegDest, Jump, Branch, MemRead, MemWrite,
           ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall, ALUControl,
           NextInstructionAddress
  );

  modport slave (
    input  Instr, Instr_PC_Plus4, RegisterValue, RegA, RegB, RegC,
           WriteReg, WriteData, Write,
    output DataA, DataB, DataC, Link, RegDest, Jump, Branch, MemRead, MemWrite,
           ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall, ALUControl,
           NextInstructionAddress
  );
endinterface

`default_nettype wire

// File: rtl/decoder.sv
// MIPS decode stage: 32x32 register file with async active-low clear, plus
// purely combinational control decode and branch/jump target generation.
`default_nettype none

module decoder (
  input  logic      CLK,
  input  logic      RESET,
  decoder_if.slave  bus
);

  logic [31:0] regs [0:31];

  // Register 0 is never written; reads of it are forced to zero at the port.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.Write && (bus.WriteReg != 5'd0)) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  assign bus.DataA = (bus.RegA == 5'd0) ? 32'd0 : regs[bus.RegA];
  assign bus.DataB = (bus.RegB == 5'd0) ? 32'd0 : regs[bus.RegB];
  assign bus.DataC = (bus.RegC == 5'd0) ? 32'd0 : regs[bus.RegC];

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       link, reg_dest, jump, branch, mem_read, mem_write;
  logic       alu_src, reg_write, jump_register, sign_or_zero, syscall;
  logic [5:0] alu_control;

  assign opcode = bus.Instr[31:26];
  assign funct  = bus.Instr[5:0];
  assign rt     = bus.Instr[20:16];

  always_comb begin
    link          = 1'b0;
    reg_dest      = 1'b0;
    jump          = 1'b0;
    branch        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src       = 1'b0;
    reg_write     = 1'b0;
    jump_register = 1'b0;
    sign_or_zero  = 1'b0;
    syscall       = 1'b0;
    alu_control   = 6'h00;
    // The all-zero word is treated as a bubble, not as SLL.
    if (bus.Instr != 32'd0) begin
      case (opcode)
        6'h00: begin
          reg_dest     = 1'b1;
          sign_or_zero = 1'b1;
          reg_write    = 1'b1;
          alu_control  = funct;
          case (funct)
            6'h08: begin
              reg_write     = 1'b0;
              jump          = 1'b1;
              jump_register = 1'b1;
              branch        = 1'b1;
            end
            6'h09: begin
              link          = 1'b1;
              jump          = 1'b1;
              jump_register = 1'b1;
              branch        = 1'b1;
            end
            6'h0C: begin
              reg_write = 1'b0;
              syscall   = 1'b1;
            end
            6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: reg_write = 1'b0;
            default: ;
          endcase
        end
        6'h01: begin
          if ((rt == 5'h00) || (rt == 5'h01) || (rt == 5'h10) || (rt == 5'h11)) begin
            branch       = 1'b1;
            sign_or_zero = 1'b1;
            alu_control  = 6'h21;
            link         = rt[4];
            reg_write    = rt[4];
          end
        end
        6'h02, 6'h03: begin
          jump         = 1'b1;
          branch       = 1'b1;
          sign_or_zero = 1'b1;
          alu_control  = 6'h21;
          link         = opcode[0];
          reg_write    = opcode[0];
        end
        6'h04, 6'h05, 6'h06, 6'h07: begin
          branch       = 1'b1;
          sign_or_zero = 1'b1;
          alu_control  = 6'h21;
        end
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
          alu_src      = 1'b1;
          reg_write    = 1'b1;
          sign_or_zero = ~(opcode[2] & opcode[3]);
          case (opcode[2:0])
            3'd0:    alu_control = 6'h20;
            3'd1:    alu_control = 6'h21;
            3'd2:    alu_control = 6'h2A;
            3'd3:    alu_control = 6'h2B;
            3'd4:    alu_control = 6'h24;
            3'd5:    alu_control = 6'h25;
            3'd6:    alu_control = 6'h26;
            default: alu_control = 6'h0F;
          endcase
        end
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
          mem_read     = 1'b1;
          reg_write    = 1'b1;
          alu_src      = 1'b1;
          sign_or_zero = 1'b1;
          alu_control  = 6'h21;
        end
        6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
          mem_write    = 1'b1;
          alu_src      = 1'b1;
          sign_or_zero = 1'b1;
          alu_control  = 6'h21;
        end
        6'h30: begin
          mem_read     = 1'b1;
          reg_write    = 1'b1;
          alu_src      = 1'b1;
          sign_or_zero = 1'b1;
          syscall      = 1'b1;
          alu_control  = 6'h28;
        end
        6'h38: begin
          mem_write    = 1'b1;
          reg_write    = 1'b1;
          alu_src      = 1'b1;
          sign_or_zero = 1'b1;
          syscall      = 1'b1;
          alu_control  = 6'h36;
        end
        default: ;
      endcase
    end
  end

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign branch_target = bus.Instr_PC_Plus4 +
                         {{14{bus.Instr[15]}}, bus.Instr[15:0], 2'b00};
  assign jump_target   = {bus.Instr_PC_Plus4[31:28], bus.Instr[25:0], 2'b00};

  assign bus.NextInstructionAddress = !jump         ? branch_target :
                                      jump_register ? bus.RegisterValue :
                                                      jump_target;

  assign bus.Link         = link;
  assign bus.RegDest      = reg_dest;
  assign bus.Jump         = jump;
  assign bus.Branch       = branch;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.ALUSrc       = alu_src;
  assign bus.RegWrite     = reg_write;
  assign bus.JumpRegister = jump_register;
  assign bus.SignOrZero   = sign_or_zero;
  assign bus.Syscall      = syscall;
  assign bus.ALUControl   = alu_control;

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
// Randomised self-checking bench for decoder: reference register file and
// instruction-class decode model, compared every cycle on the falling edge.
`default_nettype none

module tb_decoder;

  logic CLK;
  logic RESET;
  decoder_if bus ();

  decoder dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic link, regdest, jump, branch, memread, memwrite;
    logic alusrc, regwrite, jr, soz, sys;
    logic [5:0] alu;
  } dec_t;

  localparam logic [5:0] IMM_ALU [0:7] = '{6'h20, 6'h21, 6'h2A, 6'h2B,
                                           6'h24, 6'h25, 6'h26, 6'h0F};
  localparam logic [5:0] KNOWN_OPS [0:27] = '{
    6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
    6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
    6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E, 6'h30};

  // Decode expressed as instruction classes rather than per-opcode wiring.
  function automatic dec_t model_dec(input logic [31:0] ins);
    dec_t d;
    logic [5:0] op, fn;
    logic [4:0] rt;
    d  = '0;
    op = ins[31:26];
    fn = ins[5:0];
    rt = ins[20:16];
    if (ins == 32'd0) return d;
    if (op == 6'd0) begin
      d.regdest  = 1'b1;
      d.alu      = fn;
      d.soz      = 1'b1;
      d.regwrite = !(fn inside {6'h08, 6'h0C, 6'h11, 6'h13, [6'h18:6'h1B]});
      d.jump     = fn inside {6'h08, 6'h09};
      d.jr       = d.jump;
      d.branch   = d.jump;
      d.link     = (fn == 6'h09);
      d.sys      = (fn == 6'h0C);
      return d;
    end
    if (op == 6'd1 && !(rt inside {5'd0, 5'd1, 5'd16, 5'd17})) return d;
    if (!(op inside {[6'd1:6'd15], [6'd32:6'd38], 6'd40, 6'd41, 6'd42, 6'd43,
                     6'd46, 6'd48, 6'd56})) return d;
    d.soz = !(op inside {[6'd12:6'd15]});
    if (op inside {[6'd1:6'd7]}) begin
      d.branch = 1'b1;
      d.alu    = 6'h21;
      d.jump   = op inside {6'd2, 6'd3};
      d.link   = (op == 6'd3) || (op == 6'd1 && rt >= 5'd16);
      d.regwrite = d.link;
    end else if (op inside {[6'd8:6'd15]}) begin
      d.alusrc   = 1'b1;
      d.regwrite = 1'b1;
      d.alu      = IMM_ALU[op - 6'd8];
    end else if (op inside {[6'd32:6'd38]}) begin
      d.memread = 1'b1; d.regwrite = 1'b1; d.alusrc = 1'b1; d.alu = 6'h21;
    end else if (op == 6'd48) begin
      d.memread = 1'b1; d.regwrite = 1'b1; d.alusrc = 1'b1; d.alu = 6'h28; d.sys = 1'b1;
    end else if (op == 6'd56) begin
      d.memwrite = 1'b1; d.regwrite = 1'b1; d.alusrc = 1'b1; d.alu = 6'h36; d.sys = 1'b1;
    end else begin
      d.memwrite = 1'b1; d.alusrc = 1'b1; d.alu = 6'h21;
    end
    return d;
  endfunction

  function automatic logic [31:0] model_nia(input logic [31:0] ins, input logic [31:0] pc4,
                                            input logic [31:0] rv);
    dec_t d;
    int signed off;
    d = model_dec(ins);
    if (d.jump && d.jr) return rv;
    if (d.jump) return (pc4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 4);
    off = $signed(ins[15:0]);
    return pc4 + 32'(off * 4);
  endfunction

  logic [31:0] mdl [0:31];
  initial for (int i = 0; i < 32; i++) mdl[i] = '0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) mdl[i] <= '0;
    end else if (bus.Write && bus.WriteReg != 5'd0) begin
      mdl[bus.WriteReg] <= bus.WriteData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic dec_t dut_dec();
    return {bus.Link, bus.RegDest, bus.Jump, bus.Branch, bus.MemRead, bus.MemWrite,
            bus.ALUSrc, bus.RegWrite, bus.JumpRegister, bus.SignOrZero, bus.Syscall,
            bus.ALUControl};
  endfunction

  bit compare_on = 1'b0;

  always @(negedge CLK) begin
    if (compare_on) begin
      check("dataA", bus.DataA, mdl[bus.RegA]);
      check("dataB", bus.DataB, mdl[bus.RegB]);
      check("dataC", bus.DataC, mdl[bus.RegC]);
      check("decode", 32'(dut_dec()), 32'(model_dec(bus.Instr)));
      check("nia", bus.NextInstructionAddress,
            model_nia(bus.Instr, bus.Instr_PC_Plus4, bus.RegisterValue));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins, input logic [31:0] pc4,
                           input logic [31:0] rv);
    bus.Instr = ins;
    bus.Instr_PC_Plus4 = pc4;
    bus.RegisterValue = rv;
  endtask

  logic [31:0] rnd;
  logic [5:0]  op;

  initial begin
    RESET = 1'b0;
    set_instr(32'd0, 32'd0, 32'd0);
    bus.RegA = '0; bus.RegB = '0; bus.RegC = '0;
    bus.WriteReg = '0; bus.WriteData = '0; bus.Write = 1'b0;
    compare_on = 1'b1;
    repeat (2) step();
    RESET = 1'b1;

    // Fill every register, then clear it with reset while a write is pending.
    for (int r = 1; r < 32; r++) begin
      bus.Write = 1'b1; bus.WriteReg = 5'(r); bus.WriteData = $urandom() | 32'h1;
      step();
    end
    bus.WriteReg = 5'd7; bus.WriteData = 32'hA5A5_5A5A;
    RESET = 1'b0;
    for (int r = 1; r < 32; r += 3) begin
      bus.RegA = 5'(r); bus.RegB = 5'(r + 1); bus.RegC = 5'(r + 2);
      sample();
      check("reset_rdA", bus.DataA, 32'd0);
      check("reset_rdB", bus.DataB, 32'd0);
      check("reset_rdC", bus.DataC, 32'd0);
      step();
    end
    bus.Write = 1'b0;
    RESET = 1'b1;
    bus.RegA = 5'd7;
    sample();
    check("write_during_reset", bus.DataA, 32'd0);

    step();
    bus.Write = 1'b1; bus.WriteReg = 5'd5; bus.WriteData = 32'hDEAD_BEEF;
    step();
    bus.WriteReg = 5'd0; bus.WriteData = 32'h1234_5678;
    step();
    bus.Write = 1'b0; bus.RegA = 5'd5; bus.RegB = 5'd0; bus.RegC = 5'd5;
    sample();
    check("r5_A", bus.DataA, 32'hDEAD_BEEF);
    check("r0_B", bus.DataB, 32'd0);
    check("r5_C", bus.DataC, 32'hDEAD_BEEF);

    step();
    set_instr(32'h0232_8020, 32'h0040_0004, 32'd0);
    sample();
    check("add_regdest", 32'(bus.RegDest), 32'd1);
    check("add_regwrite", 32'(bus.RegWrite), 32'd1);
    check("add_alu", 32'(bus.ALUControl), 32'h20);
    check("add_memread", 32'(bus.MemRead), 32'd0);

    step();
    set_instr(32'h8C88_0004, 32'h0040_0008, 32'd0);
    sample();
    check("lw_flags", {28'd0, bus.MemRead, bus.ALUSrc, bus.SignOrZero, bus.RegWrite}, 32'hF);
    check("lw_alu", 32'(bus.ALUControl), 32'h21);

    step();
    set_instr(32'h1000_FFFF, 32'h0040_0010, 32'd0);
    sample();
    check("beq_target", bus.NextInstructionAddress, 32'h0040_000C);
    check("beq_branch", 32'(bus.Branch), 32'd1);

    step();
    set_instr(32'h0C10_0040, 32'h8000_0004, 32'd0);
    sample();
    check("jal_target", bus.NextInstructionAddress, 32'h8040_0100);
    check("jal_link_jump", {30'd0, bus.Link, bus.Jump}, 32'h3);

    step();
    set_instr(32'h03E0_0008, 32'h0040_0100, 32'h0000_1234);
    sample();
    check("jr_target", bus.NextInstructionAddress, 32'h0000_1234);

    step();
    set_instr(32'h0000_000C, 32'h0040_0100, 32'd0);
    sample();
    check("syscall", {30'd0, bus.Syscall, bus.RegWrite}, 32'h2);

    step();
    set_instr(32'h0000_0000, 32'h0040_0100, 32'd0);
    sample();
    check("nop_flags", 32'(dut_dec()), 32'd0);

    step();
    set_instr(32'h3C01_8000, 32'h0040_0100, 32'd0);
    sample();
    check("lui_soz_alu", {25'd0, bus.SignOrZero, bus.ALUControl}, 32'h0F);

    for (int n = 0; n < 600; n++) begin
      step();
      rnd = $urandom();
      case ($urandom_range(0, 3))
        0: bus.Instr = rnd;
        1: bus.Instr = {6'd0, rnd[25:0]};
        default: begin
          op = KNOWN_OPS[$urandom_range(0, 27)];
          if ($urandom_range(0, 7) == 0) op = 6'h38;
          bus.Instr = {op, rnd[25:0]};
        end
      endcase
      bus.Instr_PC_Plus4 = $urandom();
      bus.RegisterValue  = $urandom();
      bus.RegA = 5'($urandom_range(0, 31));
      bus.RegB = 5'($urandom_range(0, 31));
      bus.RegC = 5'($urandom_range(0, 31));
      bus.Write = ($urandom_range(0, 2) != 0);
      bus.WriteReg = ($urandom_range(0, 3) == 0) ? bus.RegA : 5'($urandom_range(0, 31));
      bus.WriteData = $urandom();
      if (n == 300) RESET = 1'b0;
      if (n == 303) RESET = 1'b1;
    end

    sample();
    compare_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
